// File: rtl/dram_wr_req_arbiter_if.sv
// Write port bundle: request channel, data channel (with last) and routed write response.
// master = the side that issues writes; slave = the side that accepts them.
interface dram_wr_req_arbiter_if #(
  parameter int REQ_W  = 64,
  parameter int DATA_W = 128,
  parameter int ID_W   = 4
);
  logic              req_valid;
  logic              req_ready;
  logic [REQ_W-1:0]  req;
  logic              data_valid;
  logic              data_ready;
  logic [DATA_W-1:0] data;
  logic              data_last;
  logic              resp_valid;
  logic              resp_ready;
  logic [ID_W-1:0]   resp_id;

  modport master (
    output req_valid, req, data_valid, data, data_last, resp_ready,
    input  req_ready, data_ready, resp_valid, resp_id
  );
  modport slave (
    input  req_valid, req, data_valid, data, data_last, resp_ready,
    output req_ready, data_ready, resp_valid, resp_id
  );
endinterface

// File: rtl/dram_wr_req_arbiter.sv
// Round-robin arbiter of wbuf/uc write requesters onto one DRAM write port; responses routed by ID.
// Optional per-requester outstanding-write limit: define DRAM_WR_ARB_OSTD_LIMIT_EN.
module dram_wr_req_arbiter #(
  parameter int          REQ_W      = 64,
  parameter int          DATA_W     = 128,
  parameter int          ID_W       = 4,
  parameter int unsigned UC_ID_BASE = 8,
  parameter int          MAX_OSTD   = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  dram_wr_req_arbiter_if.slave   wbuf,
  dram_wr_req_arbiter_if.slave   uc,
  dram_wr_req_arbiter_if.master  mem
);
  typedef enum logic {IDLE, BUSY} state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;      // 0 = wbuf, 1 = uc
  logic              rr_pref_q, rr_pref_d;
  logic              req_done_q, req_done_d;
  logic              data_done_q, data_done_d;
  logic              elig_w, elig_u, winner;
  logic              req_hs, data_last_hs;
  logic              own_req_valid, own_data_valid, own_data_last;
  logic [REQ_W-1:0]  own_req;
  logic [DATA_W-1:0] own_data;
  logic              resp_to_uc;

  assign own_req_valid  = owner_q ? uc.req_valid  : wbuf.req_valid;
  assign own_req        = owner_q ? uc.req        : wbuf.req;
  assign own_data_valid = owner_q ? uc.data_valid : wbuf.data_valid;
  assign own_data       = owner_q ? uc.data       : wbuf.data;
  assign own_data_last  = owner_q ? uc.data_last  : wbuf.data_last;

  // Response routing is stateless and works even while in reset.
  assign resp_to_uc      = 32'(mem.resp_id) >= UC_ID_BASE;
  assign wbuf.resp_valid = mem.resp_valid && !resp_to_uc;
  assign uc.resp_valid   = mem.resp_valid && resp_to_uc;
  assign wbuf.resp_id    = wbuf.resp_valid ? mem.resp_id : '0;
  assign uc.resp_id      = uc.resp_valid ? mem.resp_id : '0;
  assign mem.resp_ready  = resp_to_uc ? uc.resp_ready : wbuf.resp_ready;

`ifdef DRAM_WR_ARB_OSTD_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_OSTD + 1);
  logic [CNT_W-1:0] cnt_w_q, cnt_w_d, cnt_u_q, cnt_u_d;

  function automatic logic [CNT_W-1:0] cnt_next(logic [CNT_W-1:0] c, logic inc, logic dec);
    if (inc && !dec)               return c + 1'b1;
    if (dec && !inc && c != '0)    return c - 1'b1;
    return c;
  endfunction

  always_comb begin
    cnt_w_d = cnt_next(cnt_w_q, req_hs && !owner_q, wbuf.resp_valid && wbuf.resp_ready);
    cnt_u_d = cnt_next(cnt_u_q, req_hs && owner_q,  uc.resp_valid && uc.resp_ready);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_w_q <= '0;
      cnt_u_q <= '0;
    end else begin
      cnt_w_q <= cnt_w_d;
      cnt_u_q <= cnt_u_d;
    end
  end

  assign elig_w = wbuf.req_valid && (cnt_w_q < CNT_W'(MAX_OSTD));
  assign elig_u = uc.req_valid   && (cnt_u_q < CNT_W'(MAX_OSTD));
`else
  assign elig_w = wbuf.req_valid;
  assign elig_u = uc.req_valid;
`endif

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    rr_pref_d      = rr_pref_q;
    req_done_d     = req_done_q;
    data_done_d    = data_done_q;
    winner         = rr_pref_q;
    req_hs         = 1'b0;
    data_last_hs   = 1'b0;
    mem.req_valid  = 1'b0;
    mem.req        = '0;
    mem.data_valid = 1'b0;
    mem.data       = '0;
    mem.data_last  = 1'b0;
    wbuf.req_ready = 1'b0;
    wbuf.data_ready = 1'b0;
    uc.req_ready   = 1'b0;
    uc.data_ready  = 1'b0;
    case (state_q)
      IDLE: begin
        if (elig_w || elig_u) begin
          winner      = (elig_w && elig_u) ? rr_pref_q : elig_u;
          owner_d     = winner;
          rr_pref_d   = ~winner;
          req_done_d  = 1'b0;
          data_done_d = 1'b0;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        // Request and data channels pass through independently; each closes once done.
        if (!req_done_q) begin
          mem.req_valid = own_req_valid;
          mem.req       = own_req_valid ? own_req : '0;
          if (owner_q) uc.req_ready = mem.req_ready;
          else         wbuf.req_ready = mem.req_ready;
          req_hs = own_req_valid && mem.req_ready;
        end
        if (!data_done_q) begin
          mem.data_valid = own_data_valid;
          mem.data       = own_data_valid ? own_data : '0;
          mem.data_last  = own_data_valid && own_data_last;
          if (owner_q) uc.data_ready = mem.data_ready;
          else         wbuf.data_ready = mem.data_ready;
          data_last_hs = own_data_valid && mem.data_ready && own_data_last;
        end
        req_done_d  = req_done_q || req_hs;
        data_done_d = data_done_q || data_last_hs;
        if (req_done_d && data_done_d) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      rr_pref_q   <= 1'b0;
      req_done_q  <= 1'b0;
      data_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_pref_q   <= rr_pref_d;
      req_done_q  <= req_done_d;
      data_done_q <= data_done_d;
    end
  end
endmodule

// File: tb/tb_dram_wr_req_arbiter.sv
// Bench for dram_wr_req_arbiter: directed scenarios plus a randomized run against a transaction-order model.
module tb_dram_wr_req_arbiter;
  logic clk_i, rst_ni;
  int tests, fails;

  dram_wr_req_arbiter_if #(.REQ_W(64), .DATA_W(128), .ID_W(4)) w_if();
  dram_wr_req_arbiter_if #(.REQ_W(64), .DATA_W(128), .ID_W(4)) u_if();
  dram_wr_req_arbiter_if #(.REQ_W(64), .DATA_W(128), .ID_W(4)) m_if();

  dram_wr_req_arbiter #(.REQ_W(64), .DATA_W(128), .ID_W(4), .UC_ID_BASE(8), .MAX_OSTD(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .wbuf(w_if), .uc(u_if), .mem(m_if));

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_all();
    w_if.req_valid = 0; w_if.req = '0; w_if.data_valid = 0; w_if.data = '0; w_if.data_last = 0; w_if.resp_ready = 0;
    u_if.req_valid = 0; u_if.req = '0; u_if.data_valid = 0; u_if.data = '0; u_if.data_last = 0; u_if.resp_ready = 0;
    m_if.req_ready = 0; m_if.data_ready = 0; m_if.resp_valid = 0; m_if.resp_id = '0;
  endtask

  // Advance to just after the next rising edge; inputs are driven here, outputs sampled 1ns later.
  task automatic cyc();
    @(posedge clk_i); #2;
  endtask

  task automatic do_reset();
    rst_ni = 0; idle_all(); cyc(); rst_ni = 1;
  endtask

  task automatic test_reset();
    rst_ni = 0;
    w_if.req_valid = 1; w_if.data_valid = 1; u_if.req_valid = 1; u_if.data_valid = 1;
    m_if.req_ready = 1; m_if.data_ready = 1;
    for (int c = 0; c < 2; c++) begin
      cyc(); #1;
      tests++; if (m_if.req_valid !== 1'b0) begin fails++; $display("FAIL reset_mem_req_valid: got %b want 0", m_if.req_valid); end
      tests++; if (m_if.data_valid !== 1'b0) begin fails++; $display("FAIL reset_mem_data_valid: got %b want 0", m_if.data_valid); end
      tests++; if ({w_if.req_ready, w_if.data_ready, u_if.req_ready, u_if.data_ready} !== 4'b0) begin
        fails++; $display("FAIL reset_readies: got %b want 0000", {w_if.req_ready, w_if.data_ready, u_if.req_ready, u_if.data_ready}); end
    end
    m_if.resp_valid = 1; m_if.resp_id = 4'd9; u_if.resp_ready = 1; #1;
    tests++; if ({u_if.resp_valid, w_if.resp_valid, m_if.resp_ready} !== 3'b101) begin
      fails++; $display("FAIL reset_resp_path: got %b want 101", {u_if.resp_valid, w_if.resp_valid, m_if.resp_ready}); end
    idle_all(); rst_ni = 1;
  endtask

  task automatic test_single_wbuf();
    logic [63:0] rq; logic [127:0] d [4];
    rq = 64'hCAFE_0001;
    for (int b = 0; b < 4; b++) d[b] = {$urandom, $urandom, $urandom, $urandom};
    do_reset();
    w_if.req_valid = 1; w_if.req = rq; w_if.data_valid = 1; w_if.data = d[0];
    m_if.req_ready = 1; m_if.data_ready = 1; #1;
    tests++; if (m_if.req_valid !== 1'b0) begin fails++; $display("FAIL single_c0_req_valid: got %b want 0", m_if.req_valid); end
    for (int c = 1; c <= 4; c++) begin
      cyc();
      w_if.data = d[c-1]; w_if.data_last = (c == 4); #1;
      tests++; if (m_if.req_valid !== (c == 1)) begin fails++; $display("FAIL single_c%0d_req_valid: got %b want %b", c, m_if.req_valid, c == 1); end
      tests++; if (w_if.req_ready !== (c == 1)) begin fails++; $display("FAIL single_c%0d_req_ready: got %b want %b", c, w_if.req_ready, c == 1); end
      if (c == 1) begin
        tests++; if (m_if.req !== rq) begin fails++; $display("FAIL single_req_payload: got %h want %h", m_if.req, rq); end
      end
      tests++; if (m_if.data_valid !== 1'b1 || m_if.data !== d[c-1]) begin
        fails++; $display("FAIL single_c%0d_data: got %b/%h want 1/%h", c, m_if.data_valid, m_if.data, d[c-1]); end
      tests++; if (m_if.data_last !== (c == 4)) begin fails++; $display("FAIL single_c%0d_last: got %b want %b", c, m_if.data_last, c == 4); end
      tests++; if ({u_if.req_ready, u_if.data_ready} !== 2'b00) begin fails++; $display("FAIL single_c%0d_uc_ready: got %b want 00", c, {u_if.req_ready, u_if.data_ready}); end
    end
    cyc();
    w_if.req_valid = 0; w_if.data_last = 0; #1;
    tests++; if ({m_if.data_valid, w_if.data_ready} !== 2'b00) begin
      fails++; $display("FAIL single_idle_after: got %b want 00", {m_if.data_valid, w_if.data_ready}); end
    idle_all();
  endtask

  task automatic test_alternation();
    int iw, iu; logic exp_own; logic [63:0] exp_req;
    iw = 0; iu = 0;
    do_reset();
    m_if.req_ready = 1; m_if.data_ready = 1;
    for (int k = 0; k < 4; k++) begin
      w_if.req_valid = 1; w_if.req = 64'hA0 + 64'(iw); w_if.data_valid = 1; w_if.data = 128'hA0 + 128'(iw); w_if.data_last = 1;
      u_if.req_valid = 1; u_if.req = 64'hB0 + 64'(iu); u_if.data_valid = 1; u_if.data = 128'hB0 + 128'(iu); u_if.data_last = 1;
      #1;
      tests++; if (m_if.req_valid !== 1'b0) begin fails++; $display("FAIL alt_idle%0d_req_valid: got %b want 0", k, m_if.req_valid); end
      cyc(); #1;
      exp_own = k[0];
      exp_req = exp_own ? 64'hB0 + 64'(iu) : 64'hA0 + 64'(iw);
      tests++; if (m_if.req !== exp_req) begin fails++; $display("FAIL alt_grant%0d_req: got %h want %h", k, m_if.req, exp_req); end
      tests++; if ({w_if.req_ready, u_if.req_ready} !== {~exp_own, exp_own}) begin
        fails++; $display("FAIL alt_grant%0d_readies: got %b want %b", k, {w_if.req_ready, u_if.req_ready}, {~exp_own, exp_own}); end
      if (exp_own) iu++; else iw++;
      cyc();
    end
    idle_all();
  endtask

  task automatic test_data_before_req();
    do_reset();
    w_if.req_valid = 1; w_if.req = 64'h77; w_if.data_valid = 1; w_if.data = 128'hD0; w_if.data_last = 0;
    u_if.req_valid = 1; u_if.req = 64'h99; u_if.data_valid = 1; u_if.data = 128'hE0; u_if.data_last = 1;
    m_if.req_ready = 0; m_if.data_ready = 1; #1;
    tests++; if (m_if.req_valid !== 1'b0) begin fails++; $display("FAIL dbr_c0_req_valid: got %b want 0", m_if.req_valid); end
    cyc(); #1;
    tests++; if ({m_if.req_valid, m_if.data_valid, w_if.req_ready} !== 3'b110 || m_if.data !== 128'hD0) begin
      fails++; $display("FAIL dbr_c1: got %b data %h want 110 data d0", {m_if.req_valid, m_if.data_valid, w_if.req_ready}, m_if.data); end
    cyc(); w_if.data = 128'hD1; w_if.data_last = 1; #1;
    tests++; if (m_if.data_last !== 1'b1) begin fails++; $display("FAIL dbr_c2_last: got %b want 1", m_if.data_last); end
    cyc(); w_if.data = 128'hD2; w_if.data_last = 0; #1;
    tests++; if ({m_if.data_valid, w_if.data_ready, u_if.req_ready} !== 3'b000) begin
      fails++; $display("FAIL dbr_c3_blocked: got %b want 000", {m_if.data_valid, w_if.data_ready, u_if.req_ready}); end
    tests++; if (m_if.req !== 64'h77) begin fails++; $display("FAIL dbr_c3_req_held: got %h want 77", m_if.req); end
    cyc(); m_if.req_ready = 1; #1;
    tests++; if ({w_if.req_ready, u_if.req_ready} !== 2'b10) begin
      fails++; $display("FAIL dbr_c4_readies: got %b want 10", {w_if.req_ready, u_if.req_ready}); end
    cyc(); w_if.req_valid = 0; w_if.data_valid = 0; #1;
    tests++; if (m_if.req_valid !== 1'b0) begin fails++; $display("FAIL dbr_c5_idle: got %b want 0", m_if.req_valid); end
    cyc(); #1;
    tests++; if (m_if.req_valid !== 1'b1 || m_if.req !== 64'h99 || u_if.req_ready !== 1'b1) begin
      fails++; $display("FAIL dbr_c6_uc: got %b/%h/%b want 1/99/1", m_if.req_valid, m_if.req, u_if.req_ready); end
    idle_all();
  endtask

  task automatic test_resp();
    logic [3:0] id; logic v, wr, ur, to_uc;
    for (int k = 0; k < 20; k++) begin
      id = (k == 0) ? 4'd3 : (k == 1) ? 4'd9 : 4'($urandom_range(0, 15));
      v  = (k < 2) ? 1'b1 : 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      ur = (k < 2) ? 1'b0 : 1'($urandom_range(0, 1));
      m_if.resp_valid = v; m_if.resp_id = id; w_if.resp_ready = wr; u_if.resp_ready = ur; #1;
      to_uc = (id >= 4'd8);
      tests++; if ({w_if.resp_valid, u_if.resp_valid} !== {v && !to_uc, v && to_uc}) begin
        fails++; $display("FAIL resp_valid id%0d: got %b want %b", id, {w_if.resp_valid, u_if.resp_valid}, {v && !to_uc, v && to_uc}); end
      tests++; if (m_if.resp_ready !== (to_uc ? ur : wr)) begin
        fails++; $display("FAIL resp_ready id%0d: got %b want %b", id, m_if.resp_ready, to_uc ? ur : wr); end
    end
    idle_all();
  endtask

  task automatic test_reset_mid();
    do_reset();
    m_if.req_ready = 1; m_if.data_ready = 1;
    w_if.req_valid = 1; w_if.req = 64'h55; w_if.data_valid = 1; w_if.data = 128'h1;
    u_if.req_valid = 1; u_if.req = 64'h66;
    cyc();
    cyc(); w_if.req_valid = 0; w_if.data = 128'h2;
    cyc(); w_if.data_valid = 0; rst_ni = 0;
    cyc(); rst_ni = 1; w_if.req_valid = 1; w_if.data_valid = 1; w_if.data = 128'h1; #1;
    tests++; if ({m_if.req_valid, m_if.data_valid, w_if.req_ready, w_if.data_ready, u_if.req_ready, u_if.data_ready} !== 6'b0) begin
      fails++; $display("FAIL rstmid_outputs: got %b want 000000",
        {m_if.req_valid, m_if.data_valid, w_if.req_ready, w_if.data_ready, u_if.req_ready, u_if.data_ready}); end
    cyc(); #1;
    tests++; if ({w_if.req_ready, u_if.req_ready} !== 2'b10 || m_if.req !== 64'h55) begin
      fails++; $display("FAIL rstmid_rr_pref: got %b/%h want 10/55", {w_if.req_ready, u_if.req_ready}, m_if.req); end
    idle_all();
  endtask

  task automatic test_random();
    int nw, nu, nbw [8], nbu [8];
    logic [63:0] rqw [8], rqu [8];
    logic [127:0] dw [8][4], du [8][4];
    logic [63:0] exp_req [$]; logic [127:0] exp_dat [$]; logic exp_last [$];
    int i, j, pick, pref, wt, ut, wb, ub, ow, ou, viol, cyc_n;
    logic wrd, wdd, won, urd, udd, uon, to_uc;
    nw = $urandom_range(2, 6); nu = $urandom_range(2, 6);
    for (int k = 0; k < 8; k++) begin
      nbw[k] = $urandom_range(1, 4); nbu[k] = $urandom_range(1, 4);
      rqw[k] = {$urandom, $urandom}; rqu[k] = {$urandom, $urandom};
      for (int b = 0; b < 4; b++) begin
        dw[k][b] = {$urandom, $urandom, $urandom, $urandom};
        du[k][b] = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    // Both requesters stay pending, so transactions alternate starting with wbuf until one side runs dry.
    i = 0; j = 0; pref = 0;
    while (i < nw || j < nu) begin
      pick = (i < nw && (j >= nu || pref == 0)) ? 0 : 1;
      pref = 1 - pick;
      if (pick == 0) begin
        exp_req.push_back(rqw[i]);
        for (int b = 0; b < nbw[i]; b++) begin exp_dat.push_back(dw[i][b]); exp_last.push_back(b == nbw[i] - 1); end
        i++;
      end else begin
        exp_req.push_back(rqu[j]);
        for (int b = 0; b < nbu[j]; b++) begin exp_dat.push_back(du[j][b]); exp_last.push_back(b == nbu[j] - 1); end
        j++;
      end
    end
    do_reset();
    wt = 0; ut = 0; wb = 0; ub = 0; ow = 0; ou = 0; viol = 0; cyc_n = 0;
    wrd = 0; wdd = 0; won = 0; urd = 0; udd = 0; uon = 0;
    while ((wt < nw || ut < nu) && cyc_n < 3000) begin
      w_if.req_valid = (wt < nw) && !wrd; w_if.req = (wt < nw) ? rqw[wt] : '0;
      if (wt < nw && !wdd && !won) won = ($urandom_range(0, 2) != 0);
      w_if.data_valid = (wt < nw) && !wdd && won;
      w_if.data = (wt < nw) ? dw[wt][wb] : '0; w_if.data_last = (wt < nw) && (wb == nbw[wt] - 1);
      u_if.req_valid = (ut < nu) && !urd; u_if.req = (ut < nu) ? rqu[ut] : '0;
      if (ut < nu && !udd && !uon) uon = ($urandom_range(0, 2) != 0);
      u_if.data_valid = (ut < nu) && !udd && uon;
      u_if.data = (ut < nu) ? du[ut][ub] : '0; u_if.data_last = (ut < nu) && (ub == nbu[ut] - 1);
      m_if.req_ready = ($urandom_range(0, 3) != 0); m_if.data_ready = ($urandom_range(0, 3) != 0);
      w_if.resp_ready = 1; u_if.resp_ready = 1;
      m_if.resp_valid = (ow > 0 || ou > 0);
      if (ow > 0 && (ou == 0 || $urandom_range(0, 1) == 0)) m_if.resp_id = 4'($urandom_range(0, 7));
      else m_if.resp_id = 4'($urandom_range(8, 15));
      #1;
      if (w_if.req_ready && u_if.req_ready) viol++;
      if (m_if.req_valid && m_if.req_ready) begin
        tests++;
        if (exp_req.size() == 0) begin fails++; $display("FAIL rand_req_extra: got %h want none", m_if.req); end
        else if (m_if.req !== exp_req[0]) begin fails++; $display("FAIL rand_req_order: got %h want %h", m_if.req, exp_req[0]); void'(exp_req.pop_front()); end
        else void'(exp_req.pop_front());
      end
      if (m_if.data_valid && m_if.data_ready) begin
        tests++;
        if (exp_dat.size() == 0) begin fails++; $display("FAIL rand_data_extra: got %h want none", m_if.data); end
        else begin
          if (m_if.data !== exp_dat[0] || m_if.data_last !== exp_last[0]) begin
            fails++; $display("FAIL rand_data_order: got %h/%b want %h/%b", m_if.data, m_if.data_last, exp_dat[0], exp_last[0]); end
          void'(exp_dat.pop_front()); void'(exp_last.pop_front());
        end
      end
      if (m_if.resp_valid) begin
        to_uc = (m_if.resp_id >= 4'd8);
        tests++; if ({w_if.resp_valid, u_if.resp_valid, m_if.resp_ready} !== {!to_uc, to_uc, 1'b1}) begin
          fails++; $display("FAIL rand_resp id%0d: got %b want %b", m_if.resp_id, {w_if.resp_valid, u_if.resp_valid, m_if.resp_ready}, {!to_uc, to_uc, 1'b1}); end
        if (to_uc) ou--; else ow--;
      end
      if (w_if.req_valid && w_if.req_ready) begin wrd = 1; ow++; end
      if (w_if.data_valid && w_if.data_ready) begin won = 0; if (w_if.data_last) wdd = 1; else wb++; end
      if (wrd && wdd) begin wt++; wb = 0; wrd = 0; wdd = 0; end
      if (u_if.req_valid && u_if.req_ready) begin urd = 1; ou++; end
      if (u_if.data_valid && u_if.data_ready) begin uon = 0; if (u_if.data_last) udd = 1; else ub++; end
      if (urd && udd) begin ut++; ub = 0; urd = 0; udd = 0; end
      cyc(); cyc_n++;
    end
    tests++; if (wt != nw || ut != nu) begin fails++; $display("FAIL rand_timeout: done %0d/%0d want %0d/%0d", wt, ut, nw, nu); end
    tests++; if (exp_req.size() != 0 || exp_dat.size() != 0) begin
      fails++; $display("FAIL rand_leftover: got %0d req %0d beats pending want 0", exp_req.size(), exp_dat.size()); end
    tests++; if (viol != 0) begin fails++; $display("FAIL rand_dual_ready: got %0d cycles want 0", viol); end
    idle_all();
  endtask

`ifdef DRAM_WR_ARB_OSTD_LIMIT_EN
  task automatic test_ostd();
    logic exp_own [8];
    exp_own = '{0, 1, 0, 1, 1, 1, 1, 0};
    do_reset();
    m_if.req_ready = 1; m_if.data_ready = 1;
    for (int t = 0; t < 8; t++) begin
      w_if.req_valid = 1; w_if.req = 64'hF0 + 64'(t); w_if.data_valid = 1; w_if.data_last = 1;
      u_if.req_valid = 1; u_if.req = 64'hE0 + 64'(t); u_if.data_valid = 1; u_if.data_last = 1;
      m_if.resp_valid = (t == 6); m_if.resp_id = 4'd3; w_if.resp_ready = 1; u_if.resp_ready = 0; #1;
      tests++; if (m_if.req_valid !== 1'b0) begin fails++; $display("FAIL ostd_idle%0d: got %b want 0", t, m_if.req_valid); end
      cyc();
      m_if.resp_valid = exp_own[t]; m_if.resp_id = 4'd9; u_if.resp_ready = 1; w_if.resp_ready = 0; #1;
      tests++; if ({w_if.req_ready, u_if.req_ready} !== {~exp_own[t], exp_own[t]}) begin
        fails++; $display("FAIL ostd_grant%0d: got %b want %b", t, {w_if.req_ready, u_if.req_ready}, {~exp_own[t], exp_own[t]}); end
      cyc();
    end
    idle_all();
  endtask
`endif

  initial begin
    tests = 0; fails = 0; rst_ni = 0; idle_all();
    test_reset();
    test_single_wbuf();
    test_alternation();
    test_data_before_req();
    test_resp();
    test_reset_mid();
    test_random();
`ifdef DRAM_WR_ARB_OSTD_LIMIT_EN
    test_ostd();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
